// File: rtl/req_gnt_pkg.sv
// Shared types and default timing for the request/grant responder.
package req_gnt_pkg;

  localparam int MIN_DLY_DEF = 3;
  localparam int MAX_DLY_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_GRANT,
    S_TOUT
  } state_e;

endpackage

// File: rtl/req_gnt_responder_rise.sv
// Registered request and rising-edge detect.
module rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  output logic req_q_o,
  output logic rise_o
);

  logic req_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q <= 1'b0;
    end else begin
      req_q <= req_i;
    end
  end

  assign req_q_o = req_q;
  assign rise_o  = req_i & ~req_q;

endmodule

// File: rtl/req_gnt_responder.sv
// Request/grant responder: delayed grant gated by rdy, with timeout.
import req_gnt_pkg::*;

module req_gnt_responder #(
  parameter int MIN_DLY = MIN_DLY_DEF,
  parameter int MAX_DLY = MAX_DLY_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       rdy,
  output logic       gnt,
  output logic       busy,
  output logic       timeout,
  output logic [7:0] lat,
  output logic [7:0] err_cnt
);

  localparam logic [8:0] MIN_K = 9'(MIN_DLY);
  localparam logic [8:0] MAX_K = 9'(MAX_DLY);
  localparam logic [7:0] CNT_MAX = 8'(MAX_DLY);

  state_e     state_q;
  logic [7:0] cnt_q;
  logic       gnt_q;
  logic       busy_q;
  logic       tout_q;
  logic [7:0] lat_q;
  logic [7:0] err_q;

  logic       req_q;
  logic       rise;
  logic [8:0] k_d;
  logic       arm;
  logic       go_gnt;
  logic       go_to;

  rise_det u_rise (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req),
    .req_q_o(req_q),
    .rise_o (rise)
  );

  // k is the grant latency that would result from deciding this edge
  always_comb begin
    k_d    = (state_q == S_IDLE) ? 9'd1 : {1'b0, cnt_q} + 9'd2;
    arm    = ((state_q == S_IDLE) && rise) ||
             ((state_q == S_WAIT) && req);
    go_gnt = rdy && (k_d >= MIN_K);
    go_to  = k_d >= MAX_K;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      gnt_q   <= 1'b0;
      busy_q  <= 1'b0;
      tout_q  <= 1'b0;
      lat_q   <= 8'd0;
      err_q   <= 8'd0;
    end else begin
      tout_q <= 1'b0;
      if (state_q == S_IDLE) begin
        cnt_q <= 8'd0;
      end else if (state_q == S_WAIT && cnt_q < CNT_MAX) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (arm) begin
        busy_q <= 1'b1;
        if (go_gnt) begin
          state_q <= S_GRANT;
          gnt_q   <= 1'b1;
          lat_q   <= k_d[7:0];
        end else if (go_to) begin
          state_q <= S_TOUT;
          tout_q  <= 1'b1;
          if (err_q != 8'hFF) begin
            err_q <= err_q + 8'd1;
          end
        end else begin
          state_q <= S_WAIT;
        end
      end else if (state_q != S_IDLE && !req) begin
        state_q <= S_IDLE;
        gnt_q   <= 1'b0;
        busy_q  <= 1'b0;
      end
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign timeout = tout_q;
  assign lat     = lat_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_req_gnt_responder.sv
// Bench for req_gnt_responder: table scenarios, corner sequences, random vs model.
module req_gnt_chk (
  input logic clk,
  input logic rst_n,
  input logic req,
  input logic gnt,
  input logic timeout
);

  logic prev_req;
  logic prev_gnt;
  logic pend;
  int   age;

  // rose(req) |-> ##[3:$] (rose(gnt) || timeout), strong, reset/abort discharge
  always @(posedge clk) begin
    if (!rst_n) begin
      prev_req <= 1'b0;
      prev_gnt <= 1'b0;
      pend     <= 1'b0;
      age      <= 0;
    end else begin
      prev_req <= req;
      prev_gnt <= gnt;
      if (pend) begin
        if ((gnt && !prev_gnt) || timeout) begin
          assert (age + 1 >= 3)
            else $error("property violation: response after %0d cycles", age + 1);
          pend <= 1'b0;
        end else if (!req) begin
          pend <= 1'b0;
        end else begin
          age <= age + 1;
        end
      end else if (req && !prev_req) begin
        pend <= 1'b1;
        age  <= 0;
      end
    end
  end

  final begin
    if (pend) $error("property violation: request never answered");
  end

endmodule

bind req_gnt_responder req_gnt_chk u_chk (
  .clk    (clk),
  .rst_n  (rst_n),
  .req    (req),
  .gnt    (gnt),
  .timeout(timeout)
);

module tb_req_gnt_responder;

  localparam int MIN = 3;
  localparam int MAX = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic       rdy = 1'b0;
  logic       gnt;
  logic       busy;
  logic       timeout;
  logic [7:0] lat;
  logic [7:0] err_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  req_gnt_responder #(
    .MIN_DLY(MIN),
    .MAX_DLY(MAX)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .rdy    (rdy),
    .gnt    (gnt),
    .busy   (busy),
    .timeout(timeout),
    .lat    (lat),
    .err_cnt(err_cnt)
  );

  typedef struct {
    int a;
    int b;
    int fall;
    int exp_k;
    int exp_to;
  } scn_t;

  scn_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int         gk, tc, tr, b0;
  int         exp_lat;
  int         exp_err;
  int         sat_tc;

  bit         act;
  int         n0, g, to_e, k, e;
  bit         preq, m_gnt, m_busy, m_to;
  logic [7:0] m_lat, m_err;

  initial begin
    // rdy window [a,b] relative to the rise edge; a>b means never
    tbl = '{
      '{0, 99, 20, 3, 0},
      '{7, 99, 20, 8, 0},
      '{1, 0, 20, 0, 16},
      '{1, 0, 2, 0, 0},
      '{0, 1, 20, 0, 16},
      '{2, 2, 20, 3, 0},
      '{14, 14, 20, 15, 0},
      '{5, 99, 4, 0, 0}
    };

    step();
    step();
    chk("reset_outs", {gnt, busy, timeout, lat, err_cnt}, 0);
    rst_n = 1'b1;
    step();
    step();

    exp_lat = 0;
    exp_err = 0;
    for (int s = 0; s < 8; s++) begin
      gk = 0;
      tc = 0;
      tr = 0;
      b0 = 0;
      for (int r = 0; r <= tbl[s].fall; r++) begin
        req = (r < tbl[s].fall);
        rdy = (r >= tbl[s].a) && (r <= tbl[s].b);
        step();
        if (r == 0) b0 = int'(busy);
        if (gnt && gk == 0) gk = r + 1;
        if (timeout) begin
          tc++;
          tr = r + 1;
        end
      end
      if (tbl[s].exp_k != 0) exp_lat = tbl[s].exp_k;
      if (tbl[s].exp_to != 0) exp_err++;
      chk($sformatf("s%0d_busy_rise", s), b0, 1);
      chk($sformatf("s%0d_gnt_k", s), gk, tbl[s].exp_k);
      chk($sformatf("s%0d_to_cnt", s), tc, (tbl[s].exp_to != 0) ? 1 : 0);
      chk($sformatf("s%0d_to_at", s), tr, tbl[s].exp_to);
      chk($sformatf("s%0d_lat", s), lat, exp_lat);
      chk($sformatf("s%0d_err", s), err_cnt, exp_err);
      chk($sformatf("s%0d_idle", s), {busy, gnt}, 0);
      req = 1'b0;
      rdy = 1'b0;
      step();
      step();
    end

    // reset during WAIT with req held; rise re-detected after release
    req = 1'b1;
    rdy = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    chk("rst_mid_outs", {gnt, busy, timeout, lat, err_cnt}, 0);
    rst_n = 1'b1;
    rdy = 1'b1;
    step();
    chk("rst_rise_busy", {busy, gnt}, 2);
    step();
    chk("rst_gnt_early", gnt, 0);
    step();
    chk("rst_gnt_k3", gnt, 1);
    chk("rst_lat", lat, 3);
    chk("rst_no_to", timeout, 0);
    req = 1'b0;
    rdy = 1'b0;
    step();
    step();

    // err_cnt saturation over 256 timeouts
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    sat_tc = 0;
    for (int i = 0; i < 256; i++) begin
      req = 1'b1;
      repeat (17) begin
        step();
        if (i == 0 && timeout) sat_tc++;
      end
      req = 1'b0;
      step();
      step();
      if (i == 254) chk("err_255", err_cnt, 255);
    end
    chk("to_pulse_width", sat_tc, 1);
    chk("err_sat_hold", err_cnt, 255);
    chk("sat_no_gnt_lat", lat, 0);

    // random traffic against the transaction-level model
    rst_n = 1'b0;
    req = 1'b0;
    rdy = 1'b0;
    step();
    act = 0;
    preq = 0;
    m_lat = 0;
    m_err = 0;
    m_gnt = 0;
    m_busy = 0;
    m_to = 0;
    n0 = 0;
    g = -1;
    to_e = -1;
    e = 0;
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 11) == 0) req = ~req;
      rdy = ($urandom_range(0, 5) == 0);
      step();
      if (!rst_n) begin
        act = 0;
        preq = 0;
        m_lat = 0;
        m_err = 0;
        m_gnt = 0;
        m_busy = 0;
        m_to = 0;
      end else begin
        m_to = 0;
        if (!act && req && !preq) begin
          act = 1;
          n0 = e;
          g = -1;
          to_e = -1;
        end
        if (act) begin
          if (!req) begin
            act = 0;
          end else if (g < 0 && to_e < 0) begin
            k = e - n0 + 1;
            if (k >= MIN && rdy) begin
              g = e;
              m_lat = 8'(k);
            end else if (k >= MAX) begin
              to_e = e;
              m_to = 1;
              if (m_err != 8'd255) m_err = m_err + 8'd1;
            end
          end
        end
        m_gnt = act && (g >= 0);
        m_busy = act;
        preq = req;
      end
      e++;
      chk($sformatf("rand_c%0d_gnt_busy_to_lat_err", c),
          {gnt, busy, timeout, lat, err_cnt},
          {m_gnt, m_busy, m_to, m_lat, m_err});
    end

    rst_n = 1'b1;
    req = 1'b0;
    rdy = 1'b0;
    step();
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/req_gnt_responder.md
REQ_GNT_RESPONDER -- requirements
Module: req_gnt_responder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter MIN_DLY, default 3: minimum cycles from detected req rise to gnt sampled high; legal range 1..MAX_DLY.
REQ-003 Parameter MAX_DLY, default 16: cycle at which an ungranted request times out; legal range MIN_DLY..255.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous reset, active low.
REQ-006 req  input  1  request from initiator; level held until the initiator drops it.
REQ-007 rdy  input  1  resource ready; a grant may only be issued when it is high.
REQ-008 gnt  output  1  grant, registered.
REQ-009 busy  output  1  high while a request is pending, granted, or in timeout.
REQ-010 timeout  output  1  one-cycle pulse when a request reaches MAX_DLY without grant.
REQ-011 lat  output  8  latency k of the most recent grant, held until the next grant.
REQ-012 err_cnt  output  8  count of timeouts, saturating at 255.

Function
REQ-013 A rise SHALL be detected at posedge N when req is sampled 1 at N and was sampled 0 at N-1 (registered req_q).
REQ-014 FSM states SHALL be IDLE, WAIT, GRANT and TOUT; only IDLE accepts a rise.
REQ-015 IDLE -> WAIT on a detected rise; delay counter cleared to 0 at that edge, incremented by 1 each following edge in WAIT.
REQ-016 gnt SHALL first be sampled high at posedge N+k: k is the smallest value >= MIN_DLY with rdy sampled 1 at N+k-1; WAIT -> GRANT at N+k-1.
REQ-017 lat SHALL be loaded with k in the same edge that gnt is set.
REQ-018 If no grant is issued by k = MAX_DLY, WAIT -> TOUT at posedge N+MAX_DLY-1; timeout is sampled high at N+MAX_DLY for exactly one cycle, and err_cnt increments by 1, saturating.
REQ-019 gnt is never issued for a request that timed out; TOUT -> IDLE only when req is sampled 0.
REQ-020 GRANT holds gnt = 1 while req is sampled 1; when req is sampled 0, gnt clears at that edge and the FSM returns to IDLE.
REQ-021 If req is sampled 0 while in WAIT (abort), the FSM returns to IDLE with no gnt, no timeout and no err_cnt change.
REQ-022 rdy high before MIN_DLY SHALL NOT cause an early grant; rdy is ignored outside WAIT.
REQ-023 A req that stays high after grant or timeout is not a new rise; a new request requires req low for at least one sampled cycle.
REQ-024 busy SHALL be 1 in WAIT, GRANT and TOUT, and 0 in IDLE.
REQ-025 Counter width SHALL be 8 bits; the counter saturates at MAX_DLY and never wraps.

Reset
REQ-026 While rst_n is sampled 0, the block SHALL set state = IDLE, gnt = 0, timeout = 0, busy = 0, lat = 0, err_cnt = 0, req_q = 0 and counter = 0.
REQ-027 Reset mid-request SHALL abandon it silently, with no timeout pulse.
REQ-028 Because req_q resets to 0, req held high across reset release SHALL be detected as a rise at the first edge after release.

Structure
REQ-029 The shared package req_gnt_pkg SHALL hold the FSM state enum typedef and the default MIN_DLY/MAX_DLY constants.
REQ-030 Rise detection SHALL be a sub-module rise_det (req in, registered req_q, rise out).
REQ-031 The bench SHALL bind a checker implementing the property "rose(req) implies, after 3 or more cycles, rose(gnt) or timeout", written as a strong property.

Verification
REQ-032 rdy = 1 constant; req rises at posedge 10 -> gnt sampled high at 13, lat = 3.
REQ-033 rdy = 0 until sampled 1 at posedge 17; req rises at 10 -> gnt at 18, lat = 8.
REQ-034 rdy = 0 throughout; req rises at 10 -> timeout pulse at 26 only, gnt never high, err_cnt = 1, busy drops after req falls.
REQ-035 req rises at 10 and falls, sampled 0, at 12 with rdy = 0 -> IDLE at 12, no gnt, no timeout.
REQ-036 rst_n = 0 at posedge 14 during WAIT with req high -> all outputs reset; after release, the rise is re-detected and gnt arrives 3 cycles later with rdy = 1.
REQ-037 Force 256 timeouts -> err_cnt = 255 and holds.
